keypad_row_scanner: RTL and testbench

- Drives the 4x4 keypad rows one at a time and reads back the synchronized column lines from keypad_column_synchronizer.
- Debounces both press and release.
- Emits a single-cycle key_valid strobe with a 4-bit hex key code per debounced press. Key-held status stays asserted until release.
- Sits between the keypad pins and the display/key-history logic.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_row_scanner_key_decoder.sv | 17 +
 rtl/keypad_row_scanner.sv | 122 ++++++++++++
 tb/tb_keypad_row_scanner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and column helpers for the 4x4 keypad row scanner.
// KEY_MAP is indexed {row index, column index}. Column index 0 is the leftmost column.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, PRESS_DB, PRESSED, REL_DB} scan_state_t;

  localparam logic [0:15][3:0] KEY_MAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic is_one_hot(input logic [3:0] c);
    return (c != 4'b0000) && ((c & (c - 4'd1)) == 4'b0000);
  endfunction

  // Bit 3 of the column bus is the leftmost column (index 0).
  function automatic logic [1:0] col_to_index(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] row_onehot(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

endpackage

// File: rtl/keypad_row_scanner_key_decoder.sv
// Combinational key lookup: row index plus column sample give a hex code.
// key_ok is set only for an exactly one-hot column.
module keypad_key_decoder
  import keypad_pkg::*;
(
  input  logic [1:0] row_idx,
  input  logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_ok
);

  always_comb begin
    key_ok   = is_one_hot(column);
    key_code = KEY_MAP[{row_idx, col_to_index(column)}];
  end

endmodule

// File: rtl/keypad_row_scanner.sv
// Row-scanning 4x4 keypad controller with press and release debounce.
// It emits a one-cycle key_valid strobe per accepted press and holds key_held until release.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] stabilized_column,
  output logic [3:0] keypad_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  scan_state_t      state_reg;
  logic [1:0]       row_idx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       captured_col_reg;

  logic [3:0]       dec_col;
  logic [3:0]       dec_code;
  logic             dec_ok;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       row_idx_next;

  // While scanning, the decoder judges the live sample. Once a press is captured, it decodes the stored column.
  assign dec_col      = (state_reg == SCAN) ? stabilized_column : captured_col_reg;
  assign cnt_inc      = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign row_idx_next = row_idx_reg + 2'd1;

  keypad_key_decoder u_decoder (
    .row_idx  (row_idx_reg),
    .column   (dec_col),
    .key_code (dec_code),
    .key_ok   (dec_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= SCAN;
      row_idx_reg      <= 2'd0;
      keypad_row       <= 4'b0001;
      cnt_reg          <= '0;
      captured_col_reg <= 4'b0000;
      key_code         <= 4'h0;
      key_valid        <= 1'b0;
      key_held         <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg <= '0;
            if (dec_ok) begin
              captured_col_reg <= stabilized_column;
              state_reg        <= PRESS_DB;
            end else begin
              row_idx_reg <= row_idx_next;
              keypad_row  <= row_onehot(row_idx_next);
            end
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        PRESS_DB: begin
          if (stabilized_column != captured_col_reg) begin
            // Bounce or a moved finger abandons the press and resumes scanning at the next row.
            state_reg   <= SCAN;
            cnt_reg     <= '0;
            row_idx_reg <= row_idx_next;
            keypad_row  <= row_onehot(row_idx_next);
          end else if (cnt_reg == DEB_LAST) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
            key_code  <= dec_code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        PRESSED: begin
          if (stabilized_column == 4'b0000) begin
            state_reg <= REL_DB;
            cnt_reg   <= '0;
          end
        end

        REL_DB: begin
          if (stabilized_column != 4'b0000) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_reg   <= SCAN;
            cnt_reg     <= '0;
            key_held    <= 1'b0;
            row_idx_reg <= row_idx_next;
            keypad_row  <= row_onehot(row_idx_next);
          end else begin
            cnt_reg <= cnt_inc;
          end
        end

        default: begin
          state_reg <= SCAN;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Directed bench for keypad_row_scanner: a table of key presses plus hand-written
// sequences covering idle scanning, press and release bounce, multi-key input and reset.
module tb_keypad_row_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] stabilized_column = 4'b0000;
  logic [3:0] keypad_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_row_scanner #(
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stabilized_column (stabilized_column),
    .keypad_row        (keypad_row),
    .key_code          (key_code),
    .key_valid         (key_valid),
    .key_held          (key_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int valid_count = 0;
  int consec_count = 0;
  logic prev_valid = 1'b0;

  // Keypad model: a held key shows its column only while its row is driven.
  logic       key_down = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [3:0] key_col = 4'b0000;
  logic       force_en = 1'b0;
  logic [3:0] force_col = 4'b0000;

  typedef struct {
    logic [1:0] row;
    logic [3:0] col;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs [7];

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      valid_count++;
      if (prev_valid) consec_count++;
    end
    prev_valid = (key_valid === 1'b1);
  end

  function automatic logic [3:0] onehot(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_col();
    if (force_en) stabilized_column = force_col;
    else if (key_down && keypad_row == onehot(key_row)) stabilized_column = key_col;
    else stabilized_column = 4'b0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_col();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns just after the edge on which the target row becomes active, with its counter at 0.
  task automatic wait_row_start(input logic [1:0] r);
    logic [3:0] prev;
    logic found;
    found = 1'b0;
    prev = keypad_row;
    for (int i = 0; i < 48 && !found; i++) begin
      tick();
      if (keypad_row == onehot(r) && prev != onehot(r)) found = 1'b1;
      prev = keypad_row;
    end
    check("row_wait_timeout", found, 1'b1);
  endtask

  task automatic wait_held_low();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 24 && !done; i++) begin
      tick();
      if (key_held == 1'b0) done = 1'b1;
    end
    check("release_timeout", done, 1'b1);
  endtask

  task automatic press(input logic [1:0] r, input logic [3:0] c);
    key_row = r;
    key_col = c;
    key_down = 1'b1;
    drive_col();
  endtask

  task automatic release_key();
    key_down = 1'b0;
    drive_col();
  endtask

  initial begin
    int v0;

    vecs[0] = '{row: 2'd0, col: 4'b1000, exp_code: 4'h1};
    vecs[1] = '{row: 2'd0, col: 4'b0001, exp_code: 4'hA};
    vecs[2] = '{row: 2'd1, col: 4'b0010, exp_code: 4'h6};
    vecs[3] = '{row: 2'd2, col: 4'b1000, exp_code: 4'h7};
    vecs[4] = '{row: 2'd2, col: 4'b0001, exp_code: 4'hC};
    vecs[5] = '{row: 2'd3, col: 4'b1000, exp_code: 4'hE};
    vecs[6] = '{row: 2'd3, col: 4'b0010, exp_code: 4'hF};

    // Reset values
    ticks(2);
    check("reset_row", keypad_row, 4'b0001);
    check("reset_code", key_code, 4'h0);
    check("reset_valid", key_valid, 1'b0);
    check("reset_held", key_held, 1'b0);
    reset = 1'b0;

    // Idle scan: each row is driven for SETTLE cycles
    v0 = valid_count;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check("idle_row", keypad_row, onehot(2'((k / SETTLE) % 4)));
    end
    check("idle_held", key_held, 1'b0);
    check("idle_no_strobe", valid_count - v0, 0);

    // Clean press of '5' (row1, col1)
    wait_row_start(2'd1);
    press(2'd1, 4'b0100);
    v0 = valid_count;
    ticks(SETTLE + DEB - 1);
    check("press_not_early", key_valid, 1'b0);
    tick();
    check("press_valid", key_valid, 1'b1);
    check("press_code", key_code, 4'h5);
    check("press_held", key_held, 1'b1);
    check("press_row_frozen", keypad_row, 4'b0010);
    tick();
    check("strobe_one_cycle", key_valid, 1'b0);
    ticks(5);
    check("held_row_frozen", keypad_row, 4'b0010);
    check("press_single_strobe", valid_count - v0, 1);
    release_key();
    ticks(DEB);
    check("release_held_still", key_held, 1'b1);
    tick();
    check("release_held_drop", key_held, 1'b0);
    check("release_row_advance", keypad_row, 4'b0100);

    // Press bounce on row0: the column drops after 3 debounce cycles
    wait_row_start(2'd0);
    press(2'd0, 4'b1000);
    v0 = valid_count;
    ticks(SETTLE + 3);
    release_key();
    tick();
    check("bounce_row_advance", keypad_row, 4'b0010);
    check("bounce_held", key_held, 1'b0);
    check("bounce_code_kept", key_code, 4'h5);
    check("bounce_no_strobe", valid_count - v0, 0);

    // Release bounce on '0' (row3, col1)
    wait_row_start(2'd3);
    press(2'd3, 4'b0100);
    v0 = valid_count;
    ticks(SETTLE + DEB);
    check("zero_valid", key_valid, 1'b1);
    check("zero_code", key_code, 4'h0);
    force_en = 1'b1;
    force_col = 4'b0000;
    drive_col();
    ticks(4);
    check("relbounce_held_a", key_held, 1'b1);
    force_col = 4'b0100;
    drive_col();
    ticks(3);
    check("relbounce_held_b", key_held, 1'b1);
    force_col = 4'b0000;
    drive_col();
    ticks(DEB);
    check("relbounce_held_c", key_held, 1'b1);
    tick();
    check("relbounce_held_drop", key_held, 1'b0);
    check("relbounce_row_wrap", keypad_row, 4'b0001);
    check("relbounce_single_strobe", valid_count - v0, 1);
    force_en = 1'b0;
    release_key();

    // Two keys in row2 are ignored; a single key in row3 is accepted
    wait_row_start(2'd2);
    press(2'd2, 4'b1100);
    v0 = valid_count;
    ticks(SETTLE);
    check("multi_skip_row", keypad_row, 4'b1000);
    check("multi_no_strobe", valid_count - v0, 0);
    press(2'd3, 4'b0001);
    ticks(SETTLE + DEB);
    check("d_valid", key_valid, 1'b1);
    check("d_code", key_code, 4'hD);
    release_key();
    wait_held_low();

    // Table-driven presses
    for (int i = 0; i < 7; i++) begin
      wait_row_start(vecs[i].row);
      press(vecs[i].row, vecs[i].col);
      ticks(SETTLE + DEB);
      check("tbl_valid", key_valid, 1'b1);
      check("tbl_code", key_code, vecs[i].exp_code);
      check("tbl_held", key_held, 1'b1);
      check("tbl_row", keypad_row, onehot(vecs[i].row));
      release_key();
      wait_held_low();
      check("tbl_row_next", keypad_row, onehot(vecs[i].row + 2'd1));
    end

    // Reset while '9' is held
    wait_row_start(2'd2);
    press(2'd2, 4'b0010);
    ticks(SETTLE + DEB);
    check("nine_valid", key_valid, 1'b1);
    check("nine_code", key_code, 4'h9);
    ticks(3);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_row", keypad_row, 4'b0001);
    check("async_reset_held", key_held, 1'b0);
    check("async_reset_code", key_code, 4'h0);
    check("async_reset_valid", key_valid, 1'b0);
    release_key();
    ticks(2);
    reset = 1'b0;
    v0 = valid_count;
    ticks(20);
    check("post_reset_no_strobe", valid_count - v0, 0);
    check("post_reset_held", key_held, 1'b0);
    check("post_reset_code", key_code, 4'h0);

    check("valid_never_back_to_back", consec_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
